pc_ras_unit: RTL
================

// Module: pc_ras_unit
// PURPOSE
//  Parametrised program-counter register for the fetch stage. Adds a configurable reset
//  vector, stall, branch redirect, exception vector and a small circular return-address
//  stack (RAS) that predicts return targets. Sits at the head of the pipeline.
//  PCOut drives instruction memory. Decode/execute drive Redirect and Exception.
// PARAMETERS
//  WIDTH        32            PC width in bits
//  RESET_VECTOR 32'h00000000  PCOut value on reset
//  EXC_VECTOR   32'h00000180  next PC when Exception is asserted
//  INC          4             sequential increment (bytes per instruction)
//  RAS_DEPTH    4             RAS entries (>=2); count width = $clog2(RAS_DEPTH+1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  Stall        in   1      1 = hold PCOut and RAS unchanged
//  Redirect     in   1      resolved branch/jump; load RedirectPC
//  RedirectPC   in   WIDTH  redirect target
//  Exception    in   1      load EXC_VECTOR
//  PushRA       in   1      current instruction is a call; push PCOut+INC
//  PopRA        in   1      current instruction is a return; predict from RAS
//  PCOut        out  WIDTH  current fetch PC (registered)
//  PCPlus       out  WIDTH  PCOut+INC, combinational, wraps modulo 2^WIDTH
//  RasTop       out  WIDTH  top RAS entry; 0 when empty
//  RasCount     out  clog2  valid entries, 0..RAS_DEPTH
//  RasOverflow  out  1      sticky; set when a push overwrites the oldest entry
//  RasUnderflow out  1      one-cycle pulse; pop requested on an empty RAS
// BEHAVIOUR
//  - Reset, async on rst rise: PCOut=RESET_VECTOR; RasCount=0; top pointer=0;
//    RasOverflow=0; RasUnderflow=0. Entry storage is not cleared.
//  - Reset mid-operation discards all RAS contents.
//  - All state updates on the rising clk edge; PCOut latency is one cycle from inputs.
//  - Next-PC priority, highest first:
//    1 Exception  -> EXC_VECTOR
//    2 Redirect   -> RedirectPC
//    3 Stall      -> PCOut (hold)
//    4 PopRA with RasCount>0 -> RasTop
//    5 otherwise  -> PCPlus
//  - RAS is updated only when Exception=0, Redirect=0 and Stall=0. It is not repaired
//    on a redirect.
//  - Push only: write PCPlus at top+1 (mod RAS_DEPTH); top advances; RasCount increments,
//    saturating at RAS_DEPTH.
//  - Push when RasCount==RAS_DEPTH: oldest entry is overwritten (circular); RasOverflow<=1.
//  - Pop only, RasCount>0: top retreats (mod RAS_DEPTH); RasCount decrements.
//  - Pop only, RasCount==0: PC goes sequential; RasUnderflow pulses 1 for one cycle.
//  - Push+Pop together (call-via-return): next PC = old RasTop; top entry is replaced by
//    PCPlus in place; RasCount unchanged.
//  - Push+Pop together on an empty RAS: behaves as push only, and RasUnderflow pulses.
//  - RasUnderflow is 0 in every cycle with no underflowing pop.
//  - RasOverflow clears only on rst.
//  - All PC arithmetic is unsigned modulo 2^WIDTH. 0xFFFFFFFC + 4 -> 0x00000000.
// TESTING
//  1 Assert rst mid-cycle, clk idle -> PCOut=0, RasCount=0 immediately, before any edge;
//    release rst, 3 free edges -> PCOut 4, 8, 12.
//  2 PCOut=0x10, PushRA=1 one cycle -> RasTop=0x14, RasCount=1;
//    later PopRA=1 at PCOut=0x40 -> next PCOut=0x14, RasCount=0.
//  3 Five pushes with RAS_DEPTH=4 -> RasCount=4, RasOverflow=1, oldest push lost;
//    four pops return the last four pushed PCPlus values in LIFO order.
//  4 Stall=1 with PushRA=1 for 3 cycles -> PCOut and RasCount unchanged;
//    then Stall=1 with Redirect=1, RedirectPC=0x200 -> PCOut=0x200.
//  5 Exception=1, Redirect=1 and PopRA=1 in the same cycle -> PCOut=0x180, RAS unchanged;
//    PopRA on empty RAS -> PCOut=PCPlus, RasUnderflow high exactly one cycle.
//  6 PCOut=0xFFFFFFFC, no control -> PCOut=0x00000000;
//    Push+Pop at RasCount=2 -> PC=old top, count stays 2, top=PCPlus.

Source files
------------

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch-stage program counter with reset/exception vectors, stall,
// branch redirect and a small circular return-address stack that predicts
// return targets. The RAS entry storage itself is never reset; only the
// pointer, count and status flags are.
module pc_ras_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Stall,
    input  logic                           Redirect,
    input  logic [WIDTH-1:0]               RedirectPC,
    input  logic                           Exception,
    input  logic                           PushRA,
    input  logic                           PopRA,
    output logic [WIDTH-1:0]               PCOut,
    output logic [WIDTH-1:0]               PCPlus,
    output logic [WIDTH-1:0]               RasTop,
    output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount,
    output logic                           RasOverflow,
    output logic                           RasUnderflow
);

    localparam int               PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0]    TOP_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top_ptr;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic [PW-1:0]    top_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] pc_next;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             ovf_set;
    logic             unf_next;
    logic             upd_en;
    logic             do_push;
    logic             do_pop;
    logic             ras_empty;
    logic             ras_full;

    assign PCPlus    = PCOut + INC_W;
    assign ras_empty = (RasCount == {CW{1'b0}});
    assign ras_full  = (RasCount == CNT_FULL);
    assign RasTop    = ras_empty ? {WIDTH{1'b0}} : ras_mem[top_ptr];

    // RAS only moves on a clean, unstalled cycle; redirects do not repair it.
    assign upd_en  = ~Exception & ~Redirect & ~Stall;
    assign do_push = upd_en & PushRA;
    assign do_pop  = upd_en & PopRA;

    // Circular neighbours of the top pointer (depth need not be a power of two).
    always_comb begin
        top_inc = (top_ptr == TOP_LAST) ? {PW{1'b0}} : top_ptr + PW'(1);
        top_dec = (top_ptr == {PW{1'b0}}) ? TOP_LAST : top_ptr - PW'(1);
    end

    // Next-PC selection: exception, redirect, stall, predicted return, sequential.
    always_comb begin
        pc_next = PCPlus;
        if (Exception) begin
            pc_next = EXC_VECTOR;
        end else if (Redirect) begin
            pc_next = RedirectPC;
        end else if (Stall) begin
            pc_next = PCOut;
        end else if (PopRA && !ras_empty) begin
            pc_next = RasTop;
        end else begin
            pc_next = PCPlus;
        end
    end

    // Next RAS pointer/count/flags and entry write for push, pop and call-via-return.
    always_comb begin
        top_next   = top_ptr;
        count_next = RasCount;
        wr_en      = 1'b0;
        wr_idx     = top_inc;
        ovf_set    = 1'b0;
        unf_next   = 1'b0;
        case ({do_push, do_pop})
            2'b10: begin
                wr_en      = 1'b1;
                wr_idx     = top_inc;
                top_next   = top_inc;
                count_next = ras_full ? RasCount : RasCount + CW'(1);
                ovf_set    = ras_full;
            end
            2'b01: begin
                if (!ras_empty) begin
                    top_next   = top_dec;
                    count_next = RasCount - CW'(1);
                end else begin
                    unf_next   = 1'b1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (ras_empty) begin
                    // Nothing to return to: degrade to a plain push.
                    wr_idx     = top_inc;
                    top_next   = top_inc;
                    count_next = CW'(1);
                    unf_next   = 1'b1;
                end else begin
                    wr_idx     = top_ptr;
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // PC, RAS pointer, count and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCOut        <= RESET_VECTOR;
            top_ptr      <= {PW{1'b0}};
            RasCount     <= {CW{1'b0}};
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else begin
            PCOut        <= pc_next;
            top_ptr      <= top_next;
            RasCount     <= count_next;
            RasOverflow  <= RasOverflow | ovf_set;
            RasUnderflow <= unf_next;
        end
    end

    // RAS entry storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= PCPlus;
        end
    end

endmodule
